gbt_frame_checker: RTL and testbench

- Sits directly downstream of the GBT receive interface of gbt_zynq_usplus.
- Consumes the 64-bit motor_data_b64 field of each received frame and checks it against the link-test pattern driven by the far-end generator: frame k carries {n,n}, with n incrementing by 1 per frame modulo 2^32.
- Reports pattern lock, error counts and lock-loss events for link qualification and for the vfc/mcoi loopback benches.

---
 rtl/gbt_frame_checker.sv | 143 ++++++++++++++
 tb/tb_gbt_frame_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gbt_frame_checker.sv
// Link-test pattern checker for the GBT rx motor_data_b64 field: locks onto an
// incrementing {n,n} sequence and keeps error / frame / lock-loss statistics.
module gbt_frame_checker #(
  parameter int LOCK_FRAMES   = 8,
  parameter int UNLOCK_ERRORS = 4,
  parameter int ERRCNT_W      = 32
) (
  input  logic                Clk_ik,
  input  logic                Rst_irn,
  input  logic                RxReady_i,
  input  logic                RxClken_i,
  input  logic [63:0]         Data_ib64,
  input  logic                ResetCounters_i,
  output logic                Locked_o,
  output logic                ErrorStrobe_o,
  output logic [ERRCNT_W-1:0] FrameCnt_ob,
  output logic [ERRCNT_W-1:0] ErrorCnt_ob,
  output logic [15:0]         LockLossCnt_ob16,
  output logic [31:0]         Expected_ob32
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_ERRORS);

  logic [1:0]          state_q, state_d;
  logic [31:0]         exp_q, exp_d;
  logic [7:0]          good_q, good_d;
  logic [7:0]          bad_q, bad_d;
  logic                strobe_q, strobe_d;
  logic [ERRCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]         loss_cnt_q, loss_cnt_d;

  logic [31:0] hi, lo;
  logic        consistent, match, loss_evt;

  assign hi         = Data_ib64[63:32];
  assign lo         = Data_ib64[31:0];
  assign consistent = (hi == lo);
  assign match      = consistent && (lo == exp_q);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_d      = good_q;
    bad_d       = bad_q;
    strobe_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    loss_evt    = 1'b0;

    if (!RxReady_i) begin
      state_d  = ST_UNLOCKED;
      loss_evt = (state_q == ST_LOCKED);
    end else if (RxClken_i) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (consistent) begin
            exp_d   = lo + 32'd1;
            good_d  = 8'd1;
            state_d = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (match) begin
            exp_d  = exp_q + 32'd1;
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_N) begin
              state_d = ST_LOCKED;
              bad_d   = 8'd0;
            end
          end else if (consistent) begin
            exp_d  = lo + 32'd1;
            good_d = 8'd1;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          // expected advances even on bad frames so one corrupt frame keeps alignment
          exp_d = exp_q + 32'd1;
          if (~&frame_cnt_q) frame_cnt_d = frame_cnt_q + ERRCNT_W'(1);
          if (match) begin
            bad_d = 8'd0;
          end else begin
            strobe_d = 1'b1;
            bad_d    = bad_q + 8'd1;
            if (~&err_cnt_q) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            if (bad_q + 8'd1 == UNLOCK_N) begin
              state_d  = ST_UNLOCKED;
              loss_evt = 1'b1;
            end
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end

    if (loss_evt && ~&loss_cnt_q) loss_cnt_d = loss_cnt_q + 16'd1;

    // statistics clear overrides any increment from this same frame
    if (ResetCounters_i) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      loss_cnt_d  = '0;
    end
  end

  always_ff @(posedge Clk_ik) begin
    if (!Rst_irn) begin
      state_q     <= ST_UNLOCKED;
      exp_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      strobe_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      strobe_q    <= strobe_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign Locked_o         = (state_q == ST_LOCKED);
  assign ErrorStrobe_o    = strobe_q;
  assign FrameCnt_ob      = frame_cnt_q;
  assign ErrorCnt_ob      = err_cnt_q;
  assign LockLossCnt_ob16 = loss_cnt_q;
  assign Expected_ob32    = exp_q;

endmodule

// File: tb/tb_gbt_frame_checker.sv
// Directed bench for gbt_frame_checker: a per-cycle reference model plus
// literal checkpoints taken from hand-worked scenarios.
module tb_gbt_frame_checker;
  localparam int CW = 8;  // narrow counters so saturation is reachable
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_ready = 1'b0;
  logic          clken = 1'b0;
  logic [63:0]   data = '0;
  logic          rst_cnt = 1'b0;
  logic          locked, strobe;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic [15:0]   loss_cnt;
  logic [31:0]   expected;

  gbt_frame_checker #(.LOCK_FRAMES(8), .UNLOCK_ERRORS(4), .ERRCNT_W(CW)) dut (
    .Clk_ik(clk), .Rst_irn(rst_n), .RxReady_i(rx_ready), .RxClken_i(clken),
    .Data_ib64(data), .ResetCounters_i(rst_cnt), .Locked_o(locked),
    .ErrorStrobe_o(strobe), .FrameCnt_ob(frame_cnt), .ErrorCnt_ob(err_cnt),
    .LockLossCnt_ob16(loss_cnt), .Expected_ob32(expected));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 = hunting, 1 = acquiring, 2 = locked.
  int          m_phase = 0;
  logic [31:0] m_exp = 0;
  int          m_good = 0, m_bad = 0;
  bit          m_strobe = 0;
  longint      m_frames = 0, m_errs = 0, m_loss = 0;
  bit          m_ok = 0;

  always @(posedge clk) begin
    logic [31:0] h, l;
    h = data[63:32];
    l = data[31:0];
    if (!rst_n) begin
      m_phase = 0; m_exp = 0; m_good = 0; m_bad = 0; m_strobe = 0;
      m_frames = 0; m_errs = 0; m_loss = 0;
    end else begin
      m_strobe = 0;
      if (!rx_ready) begin
        if (m_phase == 2) m_loss = (m_loss < 65535) ? m_loss + 1 : m_loss;
        m_phase = 0;
      end else if (clken) begin
        if (m_phase == 0) begin
          if (h == l) begin m_exp = l + 1; m_good = 1; m_phase = 1; end
        end else if (m_phase == 1) begin
          if (h == l && l == m_exp) begin
            m_exp = m_exp + 1; m_good = m_good + 1;
            if (m_good == 8) begin m_phase = 2; m_bad = 0; end
          end else if (h == l) begin
            m_exp = l + 1; m_good = 1;
          end else m_phase = 0;
        end else begin
          m_frames = (m_frames < CMAX) ? m_frames + 1 : m_frames;
          if (h == l && l == m_exp) m_bad = 0;
          else begin
            m_strobe = 1;
            m_errs = (m_errs < CMAX) ? m_errs + 1 : m_errs;
            m_bad = m_bad + 1;
            if (m_bad == 4) begin
              m_phase = 0;
              m_loss = (m_loss < 65535) ? m_loss + 1 : m_loss;
            end
          end
          m_exp = m_exp + 1;
        end
      end
      if (rst_cnt) begin m_frames = 0; m_errs = 0; m_loss = 0; end
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("locked", 64'(locked), 64'(m_phase == 2));
      chk("strobe", 64'(strobe), 64'(m_strobe));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      chk("err_cnt", 64'(err_cnt), 64'(m_errs));
      chk("loss_cnt", 64'(loss_cnt), 64'(m_loss));
      chk("expected", 64'(expected), 64'(m_exp));
    end
  end

  task automatic step(input logic rdy, input logic ce, input logic [63:0] d, input logic rc);
    rx_ready = rdy; clken = ce; data = d; rst_cnt = rc;
    @(negedge clk);
  endtask
  task automatic frm(input logic [31:0] h, input logic [31:0] l);
    step(1'b1, 1'b1, {h, l}, 1'b0);
  endtask
  task automatic nn(input logic [31:0] n);
    frm(n, n);
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_expected", 64'(expected), 64'd0);
    chk("rst_frames", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;

    // acquire and lock on 100..107
    for (int n = 100; n <= 106; n++) nn(n);
    chk("not_yet_locked", 64'(locked), 64'd0);
    nn(107);
    chk("lock_107", 64'(locked), 64'd1);
    chk("exp_108", 64'(expected), 64'd108);
    chk("frames_0", 64'(frame_cnt), 64'd0);

    // isolated corrupt frame at expected=200
    for (int n = 108; n <= 199; n++) nn(n);
    frm(32'h0, 32'hC8);
    chk("iso_strobe", 64'(strobe), 64'd1);
    chk("iso_errcnt", 64'(err_cnt), 64'd1);
    chk("iso_locked", 64'(locked), 64'd1);
    nn(201);
    chk("iso_strobe_off", 64'(strobe), 64'd0);
    chk("iso_exp_202", 64'(expected), 64'd202);
    chk("iso_frames", 64'(frame_cnt), 64'd94);

    // four consecutive bad frames drop lock
    step(1'b1, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) frm(32'hDEAD, 32'hBEEF);
    chk("bad3_locked", 64'(locked), 64'd1);
    frm(32'hDEAD, 32'hBEEF);
    chk("bad4_unlocked", 64'(locked), 64'd0);
    chk("bad4_loss", 64'(loss_cnt), 64'd1);
    chk("bad4_errs", 64'(err_cnt), 64'd4);
    for (int n = 500; n <= 507; n++) nn(n);
    chk("relock", 64'(locked), 64'd1);

    // acquisition reseed and fall-back to hunting
    rst_n = 1'b0;
    step(1'b1, 1'b0, 64'd0, 1'b0);
    rst_n = 1'b1;
    nn(300); nn(301); nn(302);
    nn(50);
    chk("reseed_exp", 64'(expected), 64'd51);
    frm(32'd1, 32'd2);
    frm(32'd3, 32'd4);
    chk("hunt_exp_hold", 64'(expected), 64'd51);

    // 32-bit wrap of the pattern
    for (longint n = 64'hFFFFFFF8; n <= 64'hFFFFFFFF; n++) nn(32'(n));
    chk("wrap_locked", 64'(locked), 64'd1);
    chk("wrap_exp_0", 64'(expected), 64'd0);
    nn(0); nn(1);
    chk("wrap_exp_2", 64'(expected), 64'd2);
    chk("wrap_errs", 64'(err_cnt), 64'd0);

    // rx not ready: immediate unlock, strobes ignored
    step(1'b0, 1'b1, {32'd2, 32'd2}, 1'b0);
    chk("rdy_unlock", 64'(locked), 64'd0);
    chk("rdy_loss", 64'(loss_cnt), 64'd1);
    step(1'b0, 1'b1, {32'd2, 32'd2}, 1'b0);
    step(1'b0, 1'b1, {32'd3, 32'd3}, 1'b0);
    chk("rdy_exp_hold", 64'(expected), 64'd2);
    chk("rdy_frames_hold", 64'(frame_cnt), 64'd2);
    chk("rdy_loss_once", 64'(loss_cnt), 64'd1);

    // counter clear colliding with an error frame
    for (int n = 10; n <= 17; n++) nn(n);
    frm(32'd0, 32'd1);
    chk("pre_clr_errs", 64'(err_cnt), 64'd1);
    step(1'b1, 1'b1, {32'h5, 32'h6}, 1'b1);
    chk("clr_errs", 64'(err_cnt), 64'd0);
    chk("clr_strobe", 64'(strobe), 64'd1);
    chk("clr_loss", 64'(loss_cnt), 64'd0);
    chk("clr_locked", 64'(locked), 64'd1);

    // long locked run saturates the frame counter
    for (int n = 20; n <= 290; n++) nn(n);
    chk("sat_frames", 64'(frame_cnt), 64'(CMAX));

    frm(32'h1, 32'h2);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 64'd0, 1'b0);
    chk("final_locked", 64'(locked), 64'd0);
    chk("final_strobe", 64'(strobe), 64'd0);
    chk("final_frames", 64'(frame_cnt), 64'd0);
    chk("final_errs", 64'(err_cnt), 64'd0);
    chk("final_loss", 64'(loss_cnt), 64'd0);
    chk("final_exp", 64'(expected), 64'd0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
